issue_queue: RTL and testbench

Unified reservation station between dispatch/rename and the three functional units. It accepts up to two renamed instructions per cycle and holds them until both source operands are valid. Operands become valid either at dispatch or by snooping the three complete-stage forwarding buses (f_flag/dest_r/f_data). Each cycle it issues at most one ready instruction to each of FU1..FU3. The complete stage later matches those results to ROB rows by PC.

---
 rtl/issue_queue_if.sv | 52 +++++
 rtl/issue_queue.sv | 194 +++++++++++++++++++
 tb/tb_issue_queue.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// Dispatch, forward-bus, FU-busy and issue signals of the unified reservation station.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface issue_queue_if;
    logic        iq_ready_o;
    logic        disp_valid_1, disp_valid_2;
    logic [6:0]  disp_op_1, disp_op_2, disp_pc_1, disp_pc_2;
    logic [3:0]  disp_rob_1, disp_rob_2;
    logic [1:0]  disp_fu_1, disp_fu_2;
    logic [5:0]  disp_pd_1, disp_pd_2, disp_ps1_1, disp_ps1_2, disp_ps2_1, disp_ps2_2;
    logic        disp_rdy1_1, disp_rdy1_2, disp_rdy2_1, disp_rdy2_2;
    logic [31:0] disp_v1_1, disp_v1_2, disp_v2_1, disp_v2_2, disp_imm_1, disp_imm_2;
    logic        f_flag_1, f_flag_2, f_flag_3;
    logic [5:0]  dest_r_1, dest_r_2, dest_r_3;
    logic [31:0] f_data_1, f_data_2, f_data_3;
    logic        fu_busy_1, fu_busy_2, fu_busy_3;
    logic        iss_valid_1, iss_valid_2, iss_valid_3;
    logic [6:0]  iss_op_1, iss_op_2, iss_op_3, iss_pc_1, iss_pc_2, iss_pc_3;
    logic [3:0]  iss_rob_1, iss_rob_2, iss_rob_3;
    logic [5:0]  iss_pd_1, iss_pd_2, iss_pd_3;
    logic [31:0] iss_a_1, iss_a_2, iss_a_3, iss_b_1, iss_b_2, iss_b_3;
    logic [31:0] iss_imm_1, iss_imm_2, iss_imm_3;

    modport slave (
        output iq_ready_o,
        input  disp_valid_1, disp_valid_2, disp_op_1, disp_op_2, disp_pc_1, disp_pc_2,
               disp_rob_1, disp_rob_2, disp_fu_1, disp_fu_2, disp_pd_1, disp_pd_2,
               disp_ps1_1, disp_ps1_2, disp_ps2_1, disp_ps2_2,
               disp_rdy1_1, disp_rdy1_2, disp_rdy2_1, disp_rdy2_2,
               disp_v1_1, disp_v1_2, disp_v2_1, disp_v2_2, disp_imm_1, disp_imm_2,
               f_flag_1, f_flag_2, f_flag_3, dest_r_1, dest_r_2, dest_r_3,
               f_data_1, f_data_2, f_data_3, fu_busy_1, fu_busy_2, fu_busy_3,
        output iss_valid_1, iss_valid_2, iss_valid_3, iss_op_1, iss_op_2, iss_op_3,
               iss_pc_1, iss_pc_2, iss_pc_3, iss_rob_1, iss_rob_2, iss_rob_3,
               iss_pd_1, iss_pd_2, iss_pd_3, iss_a_1, iss_a_2, iss_a_3,
               iss_b_1, iss_b_2, iss_b_3, iss_imm_1, iss_imm_2, iss_imm_3
    );

    modport master (
        input  iq_ready_o,
        output disp_valid_1, disp_valid_2, disp_op_1, disp_op_2, disp_pc_1, disp_pc_2,
               disp_rob_1, disp_rob_2, disp_fu_1, disp_fu_2, disp_pd_1, disp_pd_2,
               disp_ps1_1, disp_ps1_2, disp_ps2_1, disp_ps2_2,
               disp_rdy1_1, disp_rdy1_2, disp_rdy2_1, disp_rdy2_2,
               disp_v1_1, disp_v1_2, disp_v2_1, disp_v2_2, disp_imm_1, disp_imm_2,
               f_flag_1, f_flag_2, f_flag_3, dest_r_1, dest_r_2, dest_r_3,
               f_data_1, f_data_2, f_data_3, fu_busy_1, fu_busy_2, fu_busy_3,
        input  iss_valid_1, iss_valid_2, iss_valid_3, iss_op_1, iss_op_2, iss_op_3,
               iss_pc_1, iss_pc_2, iss_pc_3, iss_rob_1, iss_rob_2, iss_rob_3,
               iss_pd_1, iss_pd_2, iss_pd_3, iss_a_1, iss_a_2, iss_a_3,
               iss_b_1, iss_b_2, iss_b_3, iss_imm_1, iss_imm_2, iss_imm_3
    );
endinterface

// File: rtl/issue_queue.sv
// Unified reservation station: two-wide dispatch, operand wakeup from three forward
// buses, and one oldest-index issue per functional unit per cycle.
module issue_queue #(
    parameter int DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    issue_queue_if.slave  dif
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef struct packed {
        logic [6:0]  op;
        logic [6:0]  pc;
        logic [3:0]  rob;
        logic [1:0]  fu;
        logic [5:0]  pd;
        logic [5:0]  t1;
        logic        r1;
        logic [31:0] v1;
        logic [5:0]  t2;
        logic        r2;
        logic [31:0] v2;
        logic [31:0] imm;
    } entry_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [6:0]  pc;
        logic [3:0]  rob;
        logic [5:0]  pd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } iss_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       iss_valid_q, iss_valid_d;
    iss_t             iss_q [3];
    iss_t             iss_d [3];

    logic [2:0]  fflag, busy;
    logic [5:0]  fdest [3];
    logic [31:0] fdata [3];
    logic [1:0]  disp_v, acc;
    entry_t      disp_raw [2];
    entry_t      disp_e [2];
    logic [IW-1:0] free_a, free_b, slot2_idx;
    logic [2:0]    sel_vld;
    logic [IW-1:0] sel_idx [3];
    logic          iq_ready;

    assign fflag = {dif.f_flag_3, dif.f_flag_2, dif.f_flag_1};
    assign busy  = {dif.fu_busy_3, dif.fu_busy_2, dif.fu_busy_1};
    assign fdest[0] = dif.dest_r_1;  assign fdest[1] = dif.dest_r_2;  assign fdest[2] = dif.dest_r_3;
    assign fdata[0] = dif.f_data_1;  assign fdata[1] = dif.f_data_2;  assign fdata[2] = dif.f_data_3;
    assign disp_v = {dif.disp_valid_2, dif.disp_valid_1};

    assign disp_raw[0] = '{op: dif.disp_op_1, pc: dif.disp_pc_1, rob: dif.disp_rob_1,
                           fu: dif.disp_fu_1, pd: dif.disp_pd_1, t1: dif.disp_ps1_1,
                           r1: dif.disp_rdy1_1, v1: dif.disp_v1_1, t2: dif.disp_ps2_1,
                           r2: dif.disp_rdy2_1, v2: dif.disp_v2_1, imm: dif.disp_imm_1};
    assign disp_raw[1] = '{op: dif.disp_op_2, pc: dif.disp_pc_2, rob: dif.disp_rob_2,
                           fu: dif.disp_fu_2, pd: dif.disp_pd_2, t1: dif.disp_ps1_2,
                           r1: dif.disp_rdy1_2, v1: dif.disp_v1_2, t2: dif.disp_ps2_2,
                           r2: dif.disp_rdy2_2, v2: dif.disp_v2_2, imm: dif.disp_imm_2};

    assign iq_ready       = (count_q <= READY_MAX);
    assign dif.iq_ready_o = iq_ready;

    // x0 is hard-wired ready/zero; otherwise the lowest-numbered matching bus supplies the value.
    function automatic logic [32:0] resolve(input logic [5:0] tag, input logic rdy,
                                            input logic [31:0] val);
        logic [32:0] res;
        res = {rdy, val};
        if (tag == 6'd0)
            res = {1'b1, 32'd0};
        else if (!rdy)
            for (int n = 2; n >= 0; n--)
                if (fflag[n] && fdest[n] == tag) res = {1'b1, fdata[n]};
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            disp_e[k] = disp_raw[k];
            {disp_e[k].r1, disp_e[k].v1} = resolve(disp_raw[k].t1, disp_raw[k].r1, disp_raw[k].v1);
            {disp_e[k].r2, disp_e[k].v2} = resolve(disp_raw[k].t2, disp_raw[k].r2, disp_raw[k].v2);
            acc[k] = disp_v[k] && (disp_raw[k].fu != 2'd0) && iq_ready;
        end
    end

    // Free slots come from registered state only, so an entry issuing now is not reused yet.
    always_comb begin
        logic found_a, found_b;
        found_a = 1'b0;
        found_b = 1'b0;
        free_a  = '0;
        free_b  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) begin
                if (!found_a) begin
                    free_a  = IW'(i);
                    found_a = 1'b1;
                end else if (!found_b) begin
                    free_b  = IW'(i);
                    found_b = 1'b1;
                end
            end
        end
        slot2_idx = acc[0] ? free_b : free_a;
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            sel_vld[n] = 1'b0;
            sel_idx[n] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid_q[i] && ent_q[i].fu == 2'(n + 1) && ent_q[i].r1 && ent_q[i].r2
                    && !busy[n]) begin
                    sel_vld[n] = 1'b1;
                    sel_idx[n] = IW'(i);
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q + CW'(acc[0]) + CW'(acc[1])
                - CW'(sel_vld[0]) - CW'(sel_vld[1]) - CW'(sel_vld[2]);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (valid_q[i]) begin
                {ent_d[i].r1, ent_d[i].v1} = resolve(ent_q[i].t1, ent_q[i].r1, ent_q[i].v1);
                {ent_d[i].r2, ent_d[i].v2} = resolve(ent_q[i].t2, ent_q[i].r2, ent_q[i].v2);
            end
        end
        for (int n = 0; n < 3; n++) begin
            iss_valid_d[n] = sel_vld[n];
            iss_d[n]       = iss_q[n];
            if (sel_vld[n]) begin
                valid_d[sel_idx[n]] = 1'b0;
                iss_d[n] = '{op: ent_q[sel_idx[n]].op, pc: ent_q[sel_idx[n]].pc,
                             rob: ent_q[sel_idx[n]].rob, pd: ent_q[sel_idx[n]].pd,
                             a: ent_q[sel_idx[n]].v1, b: ent_q[sel_idx[n]].v2,
                             imm: ent_q[sel_idx[n]].imm};
            end
        end
        if (acc[0]) begin
            valid_d[free_a] = 1'b1;
            ent_d[free_a]   = disp_e[0];
        end
        if (acc[1]) begin
            valid_d[slot2_idx] = 1'b1;
            ent_d[slot2_idx]   = disp_e[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            count_q     <= '0;
            iss_valid_q <= '0;
            for (int n = 0; n < 3; n++) iss_q[n] <= '0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            for (int n = 0; n < 3; n++) iss_q[n] <= iss_d[n];
        end
    end

    // Payload needs no reset: valid_q alone decides whether an entry exists.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

    assign dif.iss_valid_1 = iss_valid_q[0];
    assign dif.iss_valid_2 = iss_valid_q[1];
    assign dif.iss_valid_3 = iss_valid_q[2];
    assign dif.iss_op_1  = iss_q[0].op;   assign dif.iss_op_2  = iss_q[1].op;   assign dif.iss_op_3  = iss_q[2].op;
    assign dif.iss_pc_1  = iss_q[0].pc;   assign dif.iss_pc_2  = iss_q[1].pc;   assign dif.iss_pc_3  = iss_q[2].pc;
    assign dif.iss_rob_1 = iss_q[0].rob;  assign dif.iss_rob_2 = iss_q[1].rob;  assign dif.iss_rob_3 = iss_q[2].rob;
    assign dif.iss_pd_1  = iss_q[0].pd;   assign dif.iss_pd_2  = iss_q[1].pd;   assign dif.iss_pd_3  = iss_q[2].pd;
    assign dif.iss_a_1   = iss_q[0].a;    assign dif.iss_a_2   = iss_q[1].a;    assign dif.iss_a_3   = iss_q[2].a;
    assign dif.iss_b_1   = iss_q[0].b;    assign dif.iss_b_2   = iss_q[1].b;    assign dif.iss_b_3   = iss_q[2].b;
    assign dif.iss_imm_1 = iss_q[0].imm;  assign dif.iss_imm_2 = iss_q[1].imm;  assign dif.iss_imm_3 = iss_q[2].imm;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations plus a
// behavioural reservation-station model compared against the DUT every cycle.
module tb_issue_queue;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_queue_if dif();
    issue_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .dif(dif));

    logic        d_valid [2];
    logic [6:0]  d_op [2];
    logic [6:0]  d_pc [2];
    logic [3:0]  d_rob [2];
    logic [1:0]  d_fu [2];
    logic [5:0]  d_pd [2];
    logic [5:0]  d_ps1 [2];
    logic [5:0]  d_ps2 [2];
    logic        d_rdy1 [2];
    logic        d_rdy2 [2];
    logic [31:0] d_v1 [2];
    logic [31:0] d_v2 [2];
    logic [31:0] d_imm [2];
    logic        f_flag [3];
    logic [5:0]  f_dest [3];
    logic [31:0] f_data [3];
    logic        busy [3];

    assign dif.disp_valid_1 = d_valid[0]; assign dif.disp_valid_2 = d_valid[1];
    assign dif.disp_op_1  = d_op[0];   assign dif.disp_op_2  = d_op[1];
    assign dif.disp_pc_1  = d_pc[0];   assign dif.disp_pc_2  = d_pc[1];
    assign dif.disp_rob_1 = d_rob[0];  assign dif.disp_rob_2 = d_rob[1];
    assign dif.disp_fu_1  = d_fu[0];   assign dif.disp_fu_2  = d_fu[1];
    assign dif.disp_pd_1  = d_pd[0];   assign dif.disp_pd_2  = d_pd[1];
    assign dif.disp_ps1_1 = d_ps1[0];  assign dif.disp_ps1_2 = d_ps1[1];
    assign dif.disp_ps2_1 = d_ps2[0];  assign dif.disp_ps2_2 = d_ps2[1];
    assign dif.disp_rdy1_1 = d_rdy1[0]; assign dif.disp_rdy1_2 = d_rdy1[1];
    assign dif.disp_rdy2_1 = d_rdy2[0]; assign dif.disp_rdy2_2 = d_rdy2[1];
    assign dif.disp_v1_1  = d_v1[0];   assign dif.disp_v1_2  = d_v1[1];
    assign dif.disp_v2_1  = d_v2[0];   assign dif.disp_v2_2  = d_v2[1];
    assign dif.disp_imm_1 = d_imm[0];  assign dif.disp_imm_2 = d_imm[1];
    assign dif.f_flag_1 = f_flag[0];   assign dif.f_flag_2 = f_flag[1];   assign dif.f_flag_3 = f_flag[2];
    assign dif.dest_r_1 = f_dest[0];   assign dif.dest_r_2 = f_dest[1];   assign dif.dest_r_3 = f_dest[2];
    assign dif.f_data_1 = f_data[0];   assign dif.f_data_2 = f_data[1];   assign dif.f_data_3 = f_data[2];
    assign dif.fu_busy_1 = busy[0];    assign dif.fu_busy_2 = busy[1];    assign dif.fu_busy_3 = busy[2];

    logic        g_vld [3];
    logic [6:0]  g_op [3];
    logic [6:0]  g_pc [3];
    logic [3:0]  g_rob [3];
    logic [5:0]  g_pd [3];
    logic [31:0] g_a [3];
    logic [31:0] g_b [3];
    logic [31:0] g_imm [3];
    assign g_vld[0] = dif.iss_valid_1; assign g_vld[1] = dif.iss_valid_2; assign g_vld[2] = dif.iss_valid_3;
    assign g_op[0]  = dif.iss_op_1;    assign g_op[1]  = dif.iss_op_2;    assign g_op[2]  = dif.iss_op_3;
    assign g_pc[0]  = dif.iss_pc_1;    assign g_pc[1]  = dif.iss_pc_2;    assign g_pc[2]  = dif.iss_pc_3;
    assign g_rob[0] = dif.iss_rob_1;   assign g_rob[1] = dif.iss_rob_2;   assign g_rob[2] = dif.iss_rob_3;
    assign g_pd[0]  = dif.iss_pd_1;    assign g_pd[1]  = dif.iss_pd_2;    assign g_pd[2]  = dif.iss_pd_3;
    assign g_a[0]   = dif.iss_a_1;     assign g_a[1]   = dif.iss_a_2;     assign g_a[2]   = dif.iss_a_3;
    assign g_b[0]   = dif.iss_b_1;     assign g_b[1]   = dif.iss_b_2;     assign g_b[2]   = dif.iss_b_3;
    assign g_imm[0] = dif.iss_imm_1;   assign g_imm[1] = dif.iss_imm_2;   assign g_imm[2] = dif.iss_imm_3;

    int vectors = 0;
    int miscompares = 0;
    bit en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [6:0]  op, pc;
        logic [3:0]  rob;
        logic [1:0]  fu;
        logic [5:0]  pd, t1, t2;
        logic        r1, r2;
        logic [31:0] a, b, imm;
    } ment_t;

    ment_t       m [DEPTH];
    bit          e_vld [3];
    logic [6:0]  e_op [3];
    logic [6:0]  e_pc [3];
    logic [3:0]  e_rob [3];
    logic [5:0]  e_pd [3];
    logic [31:0] e_a [3];
    logic [31:0] e_b [3];
    logic [31:0] e_imm [3];
    bit          e_rdy;

    function automatic logic [32:0] snoop(input logic [5:0] tag, input logic r, input logic [31:0] v);
        if (tag == 6'd0) return {1'b1, 32'd0};
        if (r) return {1'b1, v};
        for (int n = 0; n < 3; n++)
            if (f_flag[n] && f_dest[n] == tag) return {1'b1, f_data[n]};
        return {1'b0, v};
    endfunction

    always @(posedge clk) begin
        int fl[$];
        int pick [3];
        int nfree;
        int idx;
        logic [32:0] s;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            for (int n = 0; n < 3; n++) begin
                e_vld[n] = 1'b0; e_op[n] = '0; e_pc[n] = '0; e_rob[n] = '0;
                e_pd[n] = '0; e_a[n] = '0; e_b[n] = '0; e_imm[n] = '0;
            end
        end else begin
            fl.delete();
            for (int i = 0; i < DEPTH; i++) if (!m[i].v) fl.push_back(i);
            for (int n = 0; n < 3; n++) begin
                pick[n] = -1;
                if (!busy[n])
                    for (int i = 0; i < DEPTH; i++)
                        if (pick[n] < 0 && m[i].v && int'(m[i].fu) == n + 1 && m[i].r1 && m[i].r2)
                            pick[n] = i;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].v) begin
                    s = snoop(m[i].t1, m[i].r1, m[i].a); m[i].r1 = s[32]; m[i].a = s[31:0];
                    s = snoop(m[i].t2, m[i].r2, m[i].b); m[i].r2 = s[32]; m[i].b = s[31:0];
                end
            end
            for (int n = 0; n < 3; n++) begin
                e_vld[n] = (pick[n] >= 0);
                if (pick[n] >= 0) begin
                    e_op[n] = m[pick[n]].op;   e_pc[n] = m[pick[n]].pc;  e_rob[n] = m[pick[n]].rob;
                    e_pd[n] = m[pick[n]].pd;   e_a[n]  = m[pick[n]].a;   e_b[n]   = m[pick[n]].b;
                    e_imm[n] = m[pick[n]].imm;
                    m[pick[n]].v = 1'b0;
                end
            end
            if (fl.size() >= 2) begin
                for (int k = 0; k < 2; k++) begin
                    if (d_valid[k] && d_fu[k] != 2'd0) begin
                        idx = fl.pop_front();
                        m[idx].v = 1'b1; m[idx].op = d_op[k]; m[idx].pc = d_pc[k];
                        m[idx].rob = d_rob[k]; m[idx].fu = d_fu[k]; m[idx].pd = d_pd[k];
                        m[idx].t1 = d_ps1[k]; m[idx].t2 = d_ps2[k]; m[idx].imm = d_imm[k];
                        s = snoop(d_ps1[k], d_rdy1[k], d_v1[k]); m[idx].r1 = s[32]; m[idx].a = s[31:0];
                        s = snoop(d_ps2[k], d_rdy2[k], d_v2[k]); m[idx].r2 = s[32]; m[idx].b = s[31:0];
                    end
                end
            end
        end
        nfree = 0;
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) nfree++;
        e_rdy = (nfree >= 2);
    end

    always @(negedge clk) begin
        if (en) begin
            chk("iq_ready", 32'(dif.iq_ready_o), 32'(e_rdy));
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("iss_valid_%0d", n + 1), 32'(g_vld[n]), 32'(e_vld[n]));
                chk($sformatf("iss_op_%0d", n + 1),  32'(g_op[n]),  32'(e_op[n]));
                chk($sformatf("iss_pc_%0d", n + 1),  32'(g_pc[n]),  32'(e_pc[n]));
                chk($sformatf("iss_rob_%0d", n + 1), 32'(g_rob[n]), 32'(e_rob[n]));
                chk($sformatf("iss_pd_%0d", n + 1),  32'(g_pd[n]),  32'(e_pd[n]));
                chk($sformatf("iss_a_%0d", n + 1),   g_a[n],   e_a[n]);
                chk($sformatf("iss_b_%0d", n + 1),   g_b[n],   e_b[n]);
                chk($sformatf("iss_imm_%0d", n + 1), g_imm[n], e_imm[n]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            d_valid[k] = 1'b0; d_op[k] = '0; d_pc[k] = '0; d_rob[k] = '0; d_fu[k] = '0;
            d_pd[k] = '0; d_ps1[k] = '0; d_ps2[k] = '0; d_rdy1[k] = 1'b0; d_rdy2[k] = 1'b0;
            d_v1[k] = '0; d_v2[k] = '0; d_imm[k] = '0;
        end
        for (int n = 0; n < 3; n++) begin
            f_flag[n] = 1'b0; f_dest[n] = '0; f_data[n] = '0; busy[n] = 1'b0;
        end
    endtask

    task automatic set_slot(input int k, input logic [1:0] fu, input logic [6:0] pc,
                            input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2);
        d_valid[k] = 1'b1; d_fu[k] = fu; d_pc[k] = pc; d_op[k] = pc ^ 7'h55;
        d_rob[k] = pc[3:0]; d_pd[k] = pc[5:0] ^ 6'h2A; d_imm[k] = {25'd0, pc} + 32'h100;
        d_ps1[k] = t1; d_rdy1[k] = r1; d_v1[k] = v1;
        d_ps2[k] = t2; d_rdy2[k] = r2; d_v2[k] = v2;
    endtask

    task automatic rand_inputs(input int tmax);
        for (int k = 0; k < 2; k++) begin
            d_valid[k] = 1'($urandom_range(0, 1)); d_fu[k] = 2'($urandom_range(0, 3));
            d_pc[k] = 7'($urandom); d_op[k] = 7'($urandom); d_rob[k] = 4'($urandom);
            d_pd[k] = 6'($urandom); d_imm[k] = $urandom;
            d_ps1[k] = 6'($urandom_range(0, tmax)); d_rdy1[k] = ($urandom_range(0, 2) == 0);
            d_ps2[k] = 6'($urandom_range(0, tmax)); d_rdy2[k] = ($urandom_range(0, 2) == 0);
            d_v1[k] = $urandom; d_v2[k] = $urandom;
        end
        for (int n = 0; n < 3; n++) begin
            f_flag[n] = ($urandom_range(0, 2) == 0); f_dest[n] = 6'($urandom_range(0, tmax));
            f_data[n] = $urandom; busy[n] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // reset held two edges with random inputs
        for (int c = 0; c < 2; c++) begin
            rand_inputs(63);
            tick();
            en = 1'b1;
        end
        rst = 1'b0;
        clear_inputs();
        chk("rst_valid_1", 32'(dif.iss_valid_1), 32'd0);
        chk("rst_valid_2", 32'(dif.iss_valid_2), 32'd0);
        chk("rst_valid_3", 32'(dif.iss_valid_3), 32'd0);
        chk("rst_a_1", dif.iss_a_1, 32'd0);
        chk("rst_imm_3", dif.iss_imm_3, 32'd0);
        chk("rst_ready", 32'(dif.iq_ready_o), 32'd1);

        // both sources ready at dispatch
        set_slot(0, 2'd1, 7'h04, 6'd33, 1'b1, 32'd5, 6'd34, 1'b1, 32'd9);
        set_slot(1, 2'd2, 7'h08, 6'd35, 1'b1, 32'h11, 6'd36, 1'b1, 32'h22);
        tick();
        clear_inputs();
        chk("ready_early_1", 32'(dif.iss_valid_1), 32'd0);
        tick();
        chk("ready_valid_1", 32'(dif.iss_valid_1), 32'd1);
        chk("ready_a_1", dif.iss_a_1, 32'd5);
        chk("ready_b_1", dif.iss_b_1, 32'd9);
        chk("ready_pc_1", 32'(dif.iss_pc_1), 32'h04);
        chk("ready_valid_2", 32'(dif.iss_valid_2), 32'd1);
        chk("ready_pc_2", 32'(dif.iss_pc_2), 32'h08);
        tick();
        chk("hold_valid_1", 32'(dif.iss_valid_1), 32'd0);
        chk("hold_pc_1", 32'(dif.iss_pc_1), 32'h04);

        // wakeup from bus 2 only
        set_slot(0, 2'd1, 7'h10, 6'd40, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        tick();
        clear_inputs();
        tick();
        tick();
        chk("wait_valid_1", 32'(dif.iss_valid_1), 32'd0);
        f_flag[1] = 1'b1; f_dest[1] = 6'd40; f_data[1] = 32'd7;
        tick();
        clear_inputs();
        tick();
        chk("wake_valid_1", 32'(dif.iss_valid_1), 32'd1);
        chk("wake_a_1", dif.iss_a_1, 32'd7);
        chk("wake_b_x0", dif.iss_b_1, 32'd0);
        chk("wake_pc_1", 32'(dif.iss_pc_1), 32'h10);

        // two buses match one tag: bus 1 wins
        set_slot(0, 2'd1, 7'h12, 6'd40, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        tick();
        clear_inputs();
        tick();
        f_flag[0] = 1'b1; f_dest[0] = 6'd40; f_data[0] = 32'd3;
        f_flag[1] = 1'b1; f_dest[1] = 6'd40; f_data[1] = 32'd7;
        tick();
        clear_inputs();
        tick();
        chk("prio_valid_1", 32'(dif.iss_valid_1), 32'd1);
        chk("prio_a_1", dif.iss_a_1, 32'd3);

        // dispatch bypass, slot 2 alone
        set_slot(1, 2'd3, 7'h20, 6'd50, 1'b1, 32'd11, 6'd41, 1'b0, 32'd0);
        f_flag[2] = 1'b1; f_dest[2] = 6'd41; f_data[2] = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        tick();
        chk("byp_valid_3", 32'(dif.iss_valid_3), 32'd1);
        chk("byp_b_3", dif.iss_b_3, 32'hFFFF_FFFF);
        chk("byp_a_3", dif.iss_a_3, 32'd11);
        chk("byp_pc_3", 32'(dif.iss_pc_3), 32'h20);

        // x0 sources regardless of rdy and value
        set_slot(0, 2'd2, 7'h30, 6'd0, 1'b0, 32'h1234, 6'd0, 1'b1, 32'h55);
        tick();
        clear_inputs();
        tick();
        chk("x0_valid_2", 32'(dif.iss_valid_2), 32'd1);
        chk("x0_a_2", dif.iss_a_2, 32'd0);
        chk("x0_b_2", dif.iss_b_2, 32'd0);

        // reset while an entry is about to issue
        set_slot(0, 2'd1, 7'h31, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid_1", 32'(dif.iss_valid_1), 32'd0);
        chk("mrst_pc_1", 32'(dif.iss_pc_1), 32'd0);
        tick();
        chk("mrst_discard_1", 32'(dif.iss_valid_1), 32'd0);

        // fill 15 entries while FU3 busy
        for (int j = 0; j < 7; j++) begin
            busy[2] = 1'b1;
            set_slot(0, 2'd3, 7'(7'h40 + 2 * j), 6'd1, 1'b1, 32'(j), 6'd2, 1'b1, 32'(j + 100));
            set_slot(1, 2'd3, 7'(7'h41 + 2 * j), 6'd1, 1'b1, 32'(j), 6'd2, 1'b1, 32'(j + 200));
            tick();
        end
        clear_inputs();
        busy[2] = 1'b1;
        chk("fill14_ready", 32'(dif.iq_ready_o), 32'd1);
        set_slot(0, 2'd3, 7'h4E, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd107);
        tick();
        clear_inputs();
        busy[2] = 1'b1;
        chk("full_ready", 32'(dif.iq_ready_o), 32'd0);
        set_slot(0, 2'd3, 7'h7F, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9);
        tick();
        clear_inputs();
        busy[2] = 1'b1;
        chk("full_ignored_ready", 32'(dif.iq_ready_o), 32'd0);
        chk("full_blocked_3", 32'(dif.iss_valid_3), 32'd0);
        busy[2] = 1'b0;
        tick();
        chk("drain_valid_first", 32'(dif.iss_valid_3), 32'd1);
        chk("drain_pc_first", 32'(dif.iss_pc_3), 32'h40);
        chk("drain_ready", 32'(dif.iq_ready_o), 32'd1);
        tick();
        chk("drain_pc_second", 32'(dif.iss_pc_3), 32'h41);
        for (int j = 0; j < 13; j++) tick();
        chk("drain_valid_last", 32'(dif.iss_valid_3), 32'd1);
        chk("drain_pc_last", 32'(dif.iss_pc_3), 32'h4E);
        tick();
        chk("drain_done_3", 32'(dif.iss_valid_3), 32'd0);
        chk("drain_hold_pc", 32'(dif.iss_pc_3), 32'h4E);

        // dispatch two while three issue in the same edge
        busy[0] = 1'b1; busy[1] = 1'b1; busy[2] = 1'b1;
        set_slot(0, 2'd1, 7'h50, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2);
        set_slot(1, 2'd2, 7'h51, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd4);
        tick();
        clear_inputs();
        busy[0] = 1'b1; busy[1] = 1'b1; busy[2] = 1'b1;
        set_slot(0, 2'd3, 7'h52, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd6);
        tick();
        clear_inputs();
        set_slot(0, 2'd1, 7'h53, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd8);
        set_slot(1, 2'd2, 7'h54, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd10);
        tick();
        clear_inputs();
        chk("tri_valid_1", 32'(dif.iss_valid_1), 32'd1);
        chk("tri_valid_2", 32'(dif.iss_valid_2), 32'd1);
        chk("tri_valid_3", 32'(dif.iss_valid_3), 32'd1);
        chk("tri_pc_3", 32'(dif.iss_pc_3), 32'h52);
        tick();
        chk("tri_next_pc_1", 32'(dif.iss_pc_1), 32'h53);
        chk("tri_next_pc_2", 32'(dif.iss_pc_2), 32'h54);
        chk("tri_next_valid_3", 32'(dif.iss_valid_3), 32'd0);

        // mixed traffic over a small tag space, then wake every tag and drain
        for (int c = 0; c < 300; c++) begin
            rand_inputs(7);
            tick();
        end
        clear_inputs();
        for (int t = 1; t < 8; t++) begin
            f_flag[0] = 1'b1; f_dest[0] = 6'(t); f_data[0] = 32'(t * 3);
            tick();
        end
        clear_inputs();
        for (int c = 0; c < 40; c++) tick();
        chk("end_ready", 32'(dif.iq_ready_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
